// File: rtl/auth_pin_blk.sv
// auth_pin_blk: 8N1 UART receiver feeding a rider-power authorization FSM.
// A go code followed by a multi-byte PIN powers the platform. Wrong PINs and
// PIN timeouts count as failures, and repeated failures lock the block out
// for a fixed time.
module auth_pin_blk #(
  parameter int          BAUD_DIV    = 2604,
  parameter logic [7:0]  GO_CODE     = 8'h67,
  parameter logic [7:0]  STOP_CODE   = 8'h73,
  parameter int          PIN_LEN     = 2,
  parameter logic [31:0] PIN         = 32'h0000_3132,
  parameter int          PIN_TIMEOUT = 5_000_000,
  parameter int          MAX_FAIL    = 3,
  parameter int          LOCK_CYCLES = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic RX,
  input  logic rider_off,
  output logic pwr_up,
  output logic locked,
  output logic auth_fail
);

  localparam int BW = $clog2(BAUD_DIV) + 1;
  localparam int TW = $clog2(PIN_TIMEOUT) + 1;
  localparam int LW = $clog2(LOCK_CYCLES) + 1;
  localparam int IW = $clog2(PIN_LEN) + 1;

  localparam logic [BW-1:0] HALF_BIT   = BW'(BAUD_DIV / 2 - 1);
  localparam logic [BW-1:0] FULL_BIT   = BW'(BAUD_DIV - 1);
  localparam logic [TW-1:0] TMO_END    = TW'(PIN_TIMEOUT);
  localparam logic [LW-1:0] LOCK_END   = LW'(LOCK_CYCLES - 1);
  localparam logic [IW-1:0] LAST_IDX   = IW'((PIN_LEN > 0) ? PIN_LEN - 1 : 0);
  localparam logic [2:0]    FAIL_LIMIT = 3'(MAX_FAIL);

  typedef enum logic [1:0] {
    U_IDLE  = 2'd0,
    U_START = 2'd1,
    U_DATA  = 2'd2,
    U_STOP  = 2'd3
  } uart_state_t;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PIN  = 3'd1,
    S_PWR1 = 3'd2,
    S_PWR2 = 3'd3,
    S_LOCK = 3'd4
  } auth_state_t;

  // Expected PIN byte for a given receive index; the most significant used
  // byte of PIN is the one received first.
  function automatic logic [7:0] pin_byte(input logic [IW-1:0] idx);
    int          shift_amt;
    logic [31:0] word;
    shift_amt = (PIN_LEN - 1 - int'(idx)) * 8;
    if (shift_amt < 0) begin
      shift_amt = 0;
    end else begin
      shift_amt = shift_amt;
    end
    word = PIN >> shift_amt;
    return word[7:0];
  endfunction

  // ---------------- UART receiver ----------------
  logic              rx_meta_r, rx_sync_r, rx_prev_r;
  uart_state_t       u_state_r, u_state_nxt_s;
  logic [BW-1:0]     baud_cnt_r, baud_cnt_nxt_s;
  logic [3:0]        bit_cnt_r, bit_cnt_nxt_s;
  logic [7:0]        shift_r, shift_nxt_s;
  logic              rx_rdy_r, rx_rdy_nxt_s;
  logic [7:0]        rx_data_r, rx_data_nxt_s;

  // Two-flop synchroniser plus one delayed copy for start-edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_r <= 1'b1;
      rx_sync_r <= 1'b1;
      rx_prev_r <= 1'b1;
    end else begin
      rx_meta_r <= RX;
      rx_sync_r <= rx_meta_r;
      rx_prev_r <= rx_sync_r;
    end
  end

  // Receiver sequencing: mid-bit sampling, false-start and framing rejection.
  always_comb begin
    u_state_nxt_s  = u_state_r;
    baud_cnt_nxt_s = baud_cnt_r + 1'b1;
    bit_cnt_nxt_s  = bit_cnt_r;
    shift_nxt_s    = shift_r;
    rx_rdy_nxt_s   = 1'b0;
    rx_data_nxt_s  = rx_data_r;
    case (u_state_r)
      U_IDLE: begin
        baud_cnt_nxt_s = '0;
        bit_cnt_nxt_s  = 4'd0;
        if (!rx_sync_r && rx_prev_r) begin
          u_state_nxt_s = U_START;
        end else begin
          u_state_nxt_s = U_IDLE;
        end
      end
      U_START: begin
        if (baud_cnt_r == HALF_BIT) begin
          baud_cnt_nxt_s = '0;
          u_state_nxt_s  = rx_sync_r ? U_IDLE : U_DATA;
        end else begin
          u_state_nxt_s = U_START;
        end
      end
      U_DATA: begin
        if (baud_cnt_r == FULL_BIT) begin
          baud_cnt_nxt_s = '0;
          shift_nxt_s    = {rx_sync_r, shift_r[7:1]};
          if (bit_cnt_r == 4'd7) begin
            bit_cnt_nxt_s = 4'd0;
            u_state_nxt_s = U_STOP;
          end else begin
            bit_cnt_nxt_s = bit_cnt_r + 4'd1;
          end
        end else begin
          u_state_nxt_s = U_DATA;
        end
      end
      U_STOP: begin
        if (baud_cnt_r == FULL_BIT) begin
          baud_cnt_nxt_s = '0;
          u_state_nxt_s  = U_IDLE;
          if (rx_sync_r) begin
            rx_rdy_nxt_s  = 1'b1;
            rx_data_nxt_s = shift_r;
          end else begin
            rx_rdy_nxt_s  = 1'b0;
          end
        end else begin
          u_state_nxt_s = U_STOP;
        end
      end
      default: begin
        u_state_nxt_s  = U_IDLE;
        baud_cnt_nxt_s = '0;
      end
    endcase
  end

  // Receiver state and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      u_state_r  <= U_IDLE;
      baud_cnt_r <= '0;
      bit_cnt_r  <= 4'd0;
      shift_r    <= 8'h00;
      rx_rdy_r   <= 1'b0;
      rx_data_r  <= 8'h00;
    end else begin
      u_state_r  <= u_state_nxt_s;
      baud_cnt_r <= baud_cnt_nxt_s;
      bit_cnt_r  <= bit_cnt_nxt_s;
      shift_r    <= shift_nxt_s;
      rx_rdy_r   <= rx_rdy_nxt_s;
      rx_data_r  <= rx_data_nxt_s;
    end
  end

  // ---------------- Authorization FSM ----------------
  auth_state_t   state_r, state_nxt_s;
  logic [IW-1:0] idx_r, idx_nxt_s;
  logic          match_r, match_nxt_s, match_byte_s;
  logic [TW-1:0] tmo_cnt_r, tmo_nxt_s;
  logic [LW-1:0] lock_cnt_r, lock_nxt_s;
  logic [2:0]    fail_cnt_r, fail_cnt_nxt_s, fail_inc_s;
  logic          fail_s, attempt_done_s, attempt_ok_s;
  logic          pwr_up_r, locked_r, auth_fail_r;

  // Next-state logic: PIN collection, power states, failure counting, lockout.
  always_comb begin
    state_nxt_s    = state_r;
    idx_nxt_s      = idx_r;
    match_nxt_s    = match_r;
    match_byte_s   = 1'b0;
    tmo_nxt_s      = tmo_cnt_r;
    lock_nxt_s     = '0;
    fail_cnt_nxt_s = fail_cnt_r;
    fail_inc_s     = fail_cnt_r + 3'd1;
    fail_s         = 1'b0;
    attempt_done_s = 1'b0;
    attempt_ok_s   = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (rx_rdy_r && (rx_data_r == GO_CODE)) begin
          idx_nxt_s   = '0;
          match_nxt_s = 1'b1;
          tmo_nxt_s   = '0;
          state_nxt_s = (PIN_LEN == 0) ? S_PWR1 : S_PIN;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_PIN: begin
        // A byte arriving in the expiry cycle takes priority over the timeout.
        if (rx_rdy_r) begin
          tmo_nxt_s    = '0;
          match_byte_s = match_r & (rx_data_r == pin_byte(idx_r));
          match_nxt_s  = match_byte_s;
          if (idx_r == LAST_IDX) begin
            attempt_done_s = 1'b1;
            attempt_ok_s   = match_byte_s;
          end else begin
            idx_nxt_s = idx_r + 1'b1;
          end
        end else if (tmo_cnt_r == TMO_END) begin
          attempt_done_s = 1'b1;
          attempt_ok_s   = 1'b0;
        end else begin
          tmo_nxt_s = tmo_cnt_r + 1'b1;
        end
        if (attempt_done_s && attempt_ok_s) begin
          state_nxt_s    = S_PWR1;
          fail_cnt_nxt_s = 3'd0;
        end else if (attempt_done_s) begin
          fail_s         = 1'b1;
          fail_cnt_nxt_s = fail_inc_s;
          state_nxt_s    = (fail_inc_s == FAIL_LIMIT) ? S_LOCK : S_IDLE;
        end else begin
          state_nxt_s = S_PIN;
        end
      end
      S_PWR1: begin
        if (rx_rdy_r && (rx_data_r == STOP_CODE)) begin
          state_nxt_s = rider_off ? S_IDLE : S_PWR2;
        end else begin
          state_nxt_s = S_PWR1;
        end
      end
      S_PWR2: begin
        // Rider leaving outranks a simultaneous go code.
        if (rider_off) begin
          state_nxt_s = S_IDLE;
        end else if (rx_rdy_r && (rx_data_r == GO_CODE)) begin
          state_nxt_s = S_PWR1;
        end else begin
          state_nxt_s = S_PWR2;
        end
      end
      S_LOCK: begin
        if (lock_cnt_r == LOCK_END) begin
          state_nxt_s    = S_IDLE;
          fail_cnt_nxt_s = 3'd0;
        end else begin
          lock_nxt_s = lock_cnt_r + 1'b1;
        end
      end
      default: begin
        state_nxt_s = S_IDLE;
      end
    endcase
  end

  // FSM registers; outputs are registered from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= S_IDLE;
      idx_r       <= '0;
      match_r     <= 1'b0;
      tmo_cnt_r   <= '0;
      lock_cnt_r  <= '0;
      fail_cnt_r  <= 3'd0;
      pwr_up_r    <= 1'b0;
      locked_r    <= 1'b0;
      auth_fail_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      idx_r       <= idx_nxt_s;
      match_r     <= match_nxt_s;
      tmo_cnt_r   <= tmo_nxt_s;
      lock_cnt_r  <= lock_nxt_s;
      fail_cnt_r  <= fail_cnt_nxt_s;
      pwr_up_r    <= (state_nxt_s == S_PWR1) || (state_nxt_s == S_PWR2);
      locked_r    <= (state_nxt_s == S_LOCK);
      auth_fail_r <= fail_s;
    end
  end

  assign pwr_up    = pwr_up_r;
  assign locked    = locked_r;
  assign auth_fail = auth_fail_r;

endmodule

// File: tb/tb_auth_pin_blk.sv
// Self-checking bench for auth_pin_blk: directed scenarios plus a randomized
// byte stream checked against a behavioural authorization model.
module tb_auth_pin_blk;

  localparam int          BAUD  = 16;
  localparam int          PLEN  = 2;
  localparam logic [31:0] PINV  = 32'h0000_3132;
  localparam int          TMO   = 2000;
  localparam int          MAXF  = 2;
  localparam int          LOCKC = 500;
  localparam logic [7:0]  G     = 8'h67;
  localparam logic [7:0]  S     = 8'h73;

  logic clk = 1'b0;
  logic rst, RX, rider_off;
  logic pwr_up, locked, auth_fail;

  auth_pin_blk #(
    .BAUD_DIV(BAUD), .GO_CODE(G), .STOP_CODE(S), .PIN_LEN(PLEN), .PIN(PINV),
    .PIN_TIMEOUT(TMO), .MAX_FAIL(MAXF), .LOCK_CYCLES(LOCKC)
  ) dut (
    .clk(clk), .rst(rst), .RX(RX), .rider_off(rider_off),
    .pwr_up(pwr_up), .locked(locked), .auth_fail(auth_fail)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int fail_pulses = 0;
  int af_run = 0;
  int af_max_run = 0;
  int lock_run = 0;
  int last_lock_len = 0;
  logic mid_pwr;

  // Output monitor: counts auth_fail pulses and measures lock duration.
  always @(negedge clk) begin
    if (auth_fail) begin
      fail_pulses++;
      af_run++;
      if (af_run > af_max_run) af_max_run = af_run;
    end else begin
      af_run = 0;
    end
    if (locked) begin
      lock_run++;
    end else begin
      if (lock_run != 0) last_lock_len = lock_run;
      lock_run = 0;
    end
  end

  // Behavioural model: who is powered, PIN bytes collected so far, failures.
  logic       m_collect, m_powered, m_stopped, m_locked;
  logic [7:0] m_q[$];
  int         m_fails, m_pulses;

  function automatic void model_reset();
    m_collect = 1'b0; m_powered = 1'b0; m_stopped = 1'b0; m_locked = 1'b0;
    m_q.delete(); m_fails = 0; m_pulses = fail_pulses;
  endfunction

  function automatic void model_rider();
    if (m_powered && m_stopped && rider_off) begin
      m_powered = 1'b0; m_stopped = 1'b0;
    end
  endfunction

  function automatic void model_byte(input logic [7:0] b);
    if (m_locked) return;
    if (m_collect) begin
      m_q.push_back(b);
      if (m_q.size() == PLEN) begin
        m_collect = 1'b0;
        if (m_q[0] == 8'h31 && m_q[1] == 8'h32) begin
          m_powered = 1'b1; m_stopped = 1'b0; m_fails = 0;
        end else begin
          m_fails++; m_pulses++;
          if (m_fails == MAXF) m_locked = 1'b1;
        end
      end
    end else if (m_powered && !m_stopped) begin
      if (b == S) begin
        if (rider_off) m_powered = 1'b0;
        else m_stopped = 1'b1;
      end
    end else if (m_powered) begin
      if (b == G) m_stopped = 1'b0;
    end else begin
      if (b == G) begin
        m_collect = 1'b1; m_q.delete();
      end
    end
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic uart_tx(input logic [7:0] b, input logic stop_bit);
    RX = 1'b0; tick(BAUD);
    for (int i = 0; i < 8; i++) begin
      RX = b[i]; tick(BAUD);
    end
    mid_pwr = pwr_up;
    RX = stop_bit; tick(BAUD);
    RX = 1'b1; tick(2);
  endtask

  task automatic do_reset();
    rst = 1'b1; RX = 1'b1; rider_off = 1'b0;
    tick(1);
    rst = 1'b0;
    tick(2);
    model_reset();
  endtask

  task automatic test_reset();
    rst = 1'b1; RX = 1'b1; rider_off = 1'b0;
    tick(3);
    checks++; if (pwr_up !== 1'b0) begin errors++; $display("FAIL reset_pwr_up: got %b want 0", pwr_up); end
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked: got %b want 0", locked); end
    checks++; if (auth_fail !== 1'b0) begin errors++; $display("FAIL reset_auth_fail: got %b want 0", auth_fail); end
    rst = 1'b0;
    tick(2);
  endtask

  task automatic test_basic_auth();
    int seen;
    do_reset();
    uart_tx(8'h33, 1'b1);
    checks++; if (pwr_up !== 1'b0) begin errors++; $display("FAIL noise_byte: pwr_up got %b want 0", pwr_up); end
    uart_tx(G, 1'b1);
    uart_tx(8'h31, 1'b1);
    checks++; if (pwr_up !== 1'b0) begin errors++; $display("FAIL partial_pin: pwr_up got %b want 0", pwr_up); end
    // Last PIN byte sent by hand to check the rx_rdy to pwr_up latency.
    RX = 1'b0; tick(BAUD);
    for (int i = 0; i < 8; i++) begin
      RX = (i == 1 || i == 4 || i == 5) ? 1'b1 : 1'b0; tick(BAUD);
    end
    RX = 1'b1;
    seen = 0;
    for (int k = 0; k < 40 && seen == 0; k++) begin
      tick(1);
      if (dut.rx_rdy_r === 1'b1) seen = 1;
    end
    checks++; if (seen != 1) begin errors++; $display("FAIL rx_rdy_timeout: seen %0d want 1", seen); end
    checks++; if (pwr_up !== 1'b0) begin errors++; $display("FAIL pwr_early: pwr_up got %b want 0 during rx_rdy", pwr_up); end
    tick(1);
    checks++; if (pwr_up !== 1'b1) begin errors++; $display("FAIL pwr_latency: pwr_up got %b want 1", pwr_up); end
    tick(BAUD);
  endtask

  task automatic test_stop_ride();
    int highs;
    uart_tx(S, 1'b1);
    checks++; if (pwr_up !== 1'b1) begin errors++; $display("FAIL stop_to_pwr2: pwr_up got %b want 1", pwr_up); end
    uart_tx(G, 1'b1);
    checks++; if (pwr_up !== 1'b1) begin errors++; $display("FAIL go_to_pwr1: pwr_up got %b want 1", pwr_up); end
    rider_off = 1'b1; tick(4);
    checks++; if (pwr_up !== 1'b1) begin errors++; $display("FAIL pwr1_rider_ignored: pwr_up got %b want 1", pwr_up); end
    rider_off = 1'b0; tick(2);
    uart_tx(S, 1'b1);
    checks++; if (pwr_up !== 1'b1) begin errors++; $display("FAIL second_stop: pwr_up got %b want 1", pwr_up); end
    rider_off = 1'b1; tick(2);
    checks++; if (pwr_up !== 1'b0) begin errors++; $display("FAIL rider_off_drop: pwr_up got %b want 0", pwr_up); end
    highs = 0;
    for (int k = 0; k < 50; k++) begin
      tick(1);
      if (pwr_up !== 1'b0) highs++;
    end
    checks++; if (highs != 0) begin errors++; $display("FAIL rider_off_hold: high cycles %0d want 0", highs); end
    rider_off = 1'b0; tick(2);
  endtask

  task automatic test_lockout();
    int base;
    do_reset();
    base = fail_pulses;
    af_max_run = 0;
    uart_tx(G, 1'b1); uart_tx(8'h31, 1'b1); uart_tx(8'h33, 1'b1);
    checks++; if (fail_pulses != base + 1) begin errors++; $display("FAIL wrong_pin_pulse: pulses %0d want %0d", fail_pulses, base + 1); end
    checks++; if (pwr_up !== 1'b0 || locked !== 1'b0) begin errors++; $display("FAIL wrong_pin_idle: pwr_up %b locked %b want 0 0", pwr_up, locked); end
    uart_tx(G, 1'b1); uart_tx(8'h39, 1'b1); uart_tx(8'h39, 1'b1);
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL lock_enter: locked got %b want 1", locked); end
    checks++; if (fail_pulses != base + 2) begin errors++; $display("FAIL lock_pulses: pulses %0d want %0d", fail_pulses, base + 2); end
    uart_tx(G, 1'b1); uart_tx(8'h31, 1'b1); uart_tx(8'h32, 1'b1);
    checks++; if (locked !== 1'b1 || pwr_up !== 1'b0) begin errors++; $display("FAIL lock_ignores: locked %b pwr_up %b want 1 0", locked, pwr_up); end
    for (int k = 0; k < 200 && locked === 1'b1; k++) tick(1);
    tick(1);
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL lock_release: locked got %b want 0", locked); end
    checks++; if (last_lock_len != LOCKC) begin errors++; $display("FAIL lock_length: got %0d want %0d", last_lock_len, LOCKC); end
    checks++; if (af_max_run != 1) begin errors++; $display("FAIL pulse_width: got %0d want 1", af_max_run); end
    uart_tx(G, 1'b1); uart_tx(8'h31, 1'b1); uart_tx(8'h32, 1'b1);
    checks++; if (pwr_up !== 1'b1) begin errors++; $display("FAIL post_lock_auth: pwr_up got %b want 1", pwr_up); end
  endtask

  task automatic test_timeout();
    int base;
    do_reset();
    base = fail_pulses;
    uart_tx(G, 1'b1); uart_tx(8'h31, 1'b1);
    tick(1900);
    checks++; if (fail_pulses != base) begin errors++; $display("FAIL timeout_early: pulses %0d want %0d", fail_pulses, base); end
    for (int k = 0; k < 300 && fail_pulses == base; k++) tick(1);
    checks++; if (fail_pulses != base + 1) begin errors++; $display("FAIL timeout_pulse: pulses %0d want %0d", fail_pulses, base + 1); end
    uart_tx(8'h32, 1'b1);
    checks++; if (pwr_up !== 1'b0) begin errors++; $display("FAIL timeout_late_byte: pwr_up got %b want 0", pwr_up); end
  endtask

  task automatic test_framing();
    int base;
    do_reset();
    base = fail_pulses;
    uart_tx(G, 1'b0);
    uart_tx(8'h31, 1'b1); uart_tx(8'h32, 1'b1);
    checks++; if (pwr_up !== 1'b0) begin errors++; $display("FAIL framing_pwr: pwr_up got %b want 0", pwr_up); end
    checks++; if (fail_pulses != base) begin errors++; $display("FAIL framing_pulses: pulses %0d want %0d", fail_pulses, base); end
  endtask

  task automatic test_reset_midframe();
    int base;
    do_reset();
    base = fail_pulses;
    uart_tx(G, 1'b1); uart_tx(8'h31, 1'b1);
    RX = 1'b0; tick(BAUD);
    for (int i = 0; i < 4; i++) begin
      RX = (i == 1) ? 1'b1 : 1'b0; tick(BAUD);
    end
    rst = 1'b1; tick(1);
    checks++; if (pwr_up !== 1'b0 || locked !== 1'b0 || auth_fail !== 1'b0) begin errors++; $display("FAIL midframe_reset: pwr %b lock %b fail %b want 0 0 0", pwr_up, locked, auth_fail); end
    rst = 1'b0; RX = 1'b1;
    tick(BAUD * 7);
    model_reset();
    uart_tx(G, 1'b1); uart_tx(8'h31, 1'b1); uart_tx(8'h32, 1'b1);
    checks++; if (pwr_up !== 1'b1) begin errors++; $display("FAIL post_reset_auth: pwr_up got %b want 1", pwr_up); end
    checks++; if (fail_pulses != base) begin errors++; $display("FAIL post_reset_pulses: pulses %0d want %0d", fail_pulses, base); end
  endtask

  task automatic test_random();
    logic [7:0] seq[$];
    int r;
    do_reset();
    for (int it = 0; it < 30; it++) begin
      seq.delete();
      r = $urandom_range(0, 11);
      if (r < 3) begin
        seq.push_back(G); seq.push_back(8'h31); seq.push_back(8'h32);
      end else if (r < 6) seq.push_back(G);
      else if (r == 6) seq.push_back(S);
      else if (r == 7) seq.push_back(8'h31);
      else if (r == 8) seq.push_back(8'h32);
      else if (r == 9) seq.push_back(8'h33);
      else seq.push_back(8'($urandom));
      rider_off = ($urandom_range(0, 5) == 0);
      tick(2);
      model_rider();
      checks++; if (pwr_up !== m_powered) begin errors++; $display("FAIL rand_rider it%0d: pwr_up got %b want %b", it, pwr_up, m_powered); end
      foreach (seq[j]) begin
        uart_tx(seq[j], 1'b1);
        model_byte(seq[j]);
        checks++; if (pwr_up !== m_powered || locked !== m_locked) begin errors++; $display("FAIL rand_byte it%0d b=%h: pwr %b lock %b want %b %b", it, seq[j], pwr_up, locked, m_powered, m_locked); end
        checks++; if (fail_pulses != m_pulses) begin errors++; $display("FAIL rand_pulses it%0d: got %0d want %0d", it, fail_pulses, m_pulses); end
        if (m_locked) begin
          tick(LOCKC + 10);
          m_locked = 1'b0; m_fails = 0; m_collect = 1'b0;
          checks++; if (locked !== 1'b0) begin errors++; $display("FAIL rand_unlock it%0d: locked got %b want 0", it, locked); end
        end
      end
    end
    rider_off = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic_auth();
    test_stop_ride();
    test_lockout();
    test_timeout();
    test_framing();
    test_reset_midframe();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
